// File: rtl/tile_clkrst_seq.sv
// Per-domain tile clock/reset sequencer: brings each domain up (clock, then reset release)
// and down (drain, reset assert, then clock gate) in response to a level on/off request.
module tile_clkrst_seq #(
    parameter int unsigned NumDomains       = 4,
    parameter int unsigned RstReleaseCycles = 4,
    parameter int unsigned RstAssertCycles  = 8,
    parameter int unsigned IdleTimeout      = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_rst_bypass_i,
    input  logic [NumDomains-1:0] on_req_i,
    input  logic [NumDomains-1:0] idle_i,
    output logic [NumDomains-1:0] clk_en_o,
    output logic [NumDomains-1:0] rst_no,
    output logic [NumDomains-1:0] on_ack_o,
    output logic [NumDomains-1:0] timeout_o
);

    localparam int unsigned MaxA   = (RstReleaseCycles > RstAssertCycles) ? RstReleaseCycles
                                                                          : RstAssertCycles;
    localparam int unsigned MaxCnt = (MaxA > IdleTimeout) ? MaxA : IdleTimeout;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0] RelLast  = CntW'(RstReleaseCycles - 1);
    localparam logic [CntW-1:0] AsrtLast = CntW'(RstAssertCycles - 1);
    localparam logic [CntW-1:0] IdleLast = CntW'(IdleTimeout - 1);

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_CLK_UP = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_RST_DN = 3'd4;

    logic [2:0]            state_q [NumDomains];
    logic [2:0]            state_d [NumDomains];
    logic [CntW-1:0]       cnt_q   [NumDomains];
    logic [CntW-1:0]       cnt_d   [NumDomains];
    logic [NumDomains-1:0] timeout_q, timeout_d;
    logic [NumDomains-1:0] clk_en_q, clk_en_d;
    logic [NumDomains-1:0] rst_n_q, rst_n_d;
    logic [NumDomains-1:0] on_ack_q, on_ack_d;

    // Next-state and next-output logic, one independent FSM per domain
    always_comb begin
        timeout_d = '0;
        clk_en_d  = '0;
        rst_n_d   = '0;
        on_ack_d  = '0;
        for (int unsigned d = 0; d < NumDomains; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            case (state_q[d])
                ST_OFF: begin
                    if (on_req_i[d]) begin
                        state_d[d] = ST_CLK_UP;
                        cnt_d[d]   = '0;
                    end
                end
                ST_CLK_UP: begin
                    if (cnt_q[d] == RelLast) begin
                        state_d[d] = ST_RUN;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CntW'(1);
                    end
                end
                ST_RUN: begin
                    if (!on_req_i[d]) begin
                        state_d[d] = ST_DRAIN;
                        cnt_d[d]   = '0;
                    end
                end
                ST_DRAIN: begin
                    // A renewed request aborts the shutdown before idle/timeout are considered
                    if (on_req_i[d]) begin
                        state_d[d] = ST_RUN;
                        cnt_d[d]   = '0;
                    end else if (idle_i[d]) begin
                        state_d[d] = ST_RST_DN;
                        cnt_d[d]   = '0;
                    end else if (cnt_q[d] == IdleLast) begin
                        state_d[d]   = ST_RST_DN;
                        cnt_d[d]     = '0;
                        timeout_d[d] = 1'b1;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CntW'(1);
                    end
                end
                ST_RST_DN: begin
                    if (cnt_q[d] == AsrtLast) begin
                        state_d[d] = ST_OFF;
                        cnt_d[d]   = '0;
                    end else begin
                        cnt_d[d] = cnt_q[d] + CntW'(1);
                    end
                end
                default: begin
                    state_d[d] = ST_OFF;
                    cnt_d[d]   = '0;
                end
            endcase
            clk_en_d[d] = (state_d[d] != ST_OFF);
            rst_n_d[d]  = (state_d[d] == ST_RUN) || (state_d[d] == ST_DRAIN);
            on_ack_d[d] = (state_d[d] == ST_RUN);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned d = 0; d < NumDomains; d++) begin
                state_q[d] <= ST_OFF;
                cnt_q[d]   <= '0;
            end
            timeout_q <= '0;
            clk_en_q  <= '0;
            rst_n_q   <= '0;
            on_ack_q  <= '0;
        end else begin
            for (int unsigned d = 0; d < NumDomains; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            timeout_q <= timeout_d;
            clk_en_q  <= clk_en_d;
            rst_n_q   <= rst_n_d;
            on_ack_q  <= on_ack_d;
        end
    end

    // Bypass overrides only the clock/reset pins; sequencing continues underneath
    assign clk_en_o  = clk_rst_bypass_i ? '1 : clk_en_q;
    assign rst_no    = clk_rst_bypass_i ? {NumDomains{~rst_i}} : rst_n_q;
    assign on_ack_o  = on_ack_q;
    assign timeout_o = timeout_q;

endmodule
